crc32_mb: RTL and testbench
===========================

CRC32_MB -- requirements
Module: crc32_mb

Interface
REQ-001 Parameter DATA_WD, default 32, input beat width in bits. Legal values are 8, 16, 32 and 64; LANE = DATA_WD/8.
REQ-002 Parameter CRC_INIT, default 32'hFFFF_FFFF, value loaded into the CRC register on start.
REQ-003 Parameter XOR_OUT, default 32'hFFFF_FFFF, final XOR applied to dat_o.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  begin a new CRC computation.
REQ-007 val_i  input  1  dat_i beat valid.
REQ-008 dat_i  input  DATA_WD  message bytes; the first byte is dat_i[DATA_WD-1:DATA_WD-8].
REQ-009 lst_i  input  1  the current beat is the last beat of the message.
REQ-010 nbyte_i  input  max(1,log2(LANE))  valid bytes in the last beat, counted from the MSB end; 0 means all LANE bytes. Sampled only when lst_i is high.
REQ-011 rdy_o  output  1  block can accept a beat.
REQ-012 val_o  output  1  one-cycle pulse indicating that dat_o has been updated.
REQ-013 dat_o  output  32  finalised CRC of all bytes accepted so far.
REQ-014 done_o  output  1  one-cycle pulse coincident with val_o for the last beat.

Function
REQ-015 The FSM SHALL have two states, IDLE and ACTV, and rdy_o SHALL be 1 exactly when the state is ACTV (decoded from the state register only).
REQ-016 IDLE -> ACTV SHALL occur on start_i; the same edge SHALL load crc_r <= CRC_INIT.
REQ-017 A beat SHALL be accepted when state=ACTV and val_i=1; throughput SHALL be one beat per cycle with no stall.
REQ-018 The CRC SHALL be the reflected CRC-32 (polynomial 0x04C11DB7, reflected form 0xEDB88320), consuming each byte LSB-first, with bytes taken in order from the MSB end of dat_i.
REQ-019 On an accepted beat, crc_r SHALL advance over LANE bytes, or over nbyte_i bytes when lst_i=1 and nbyte_i!=0, all in a single cycle using combinational XOR logic.
REQ-020 On an accepted beat, val_o SHALL be registered to 1 on that edge, and dat_o SHALL be registered on that edge to the advanced crc_r ^ XOR_OUT; latency from acceptance to val_o is 1 cycle.
REQ-021 dat_o SHALL hold its value between val_o pulses.
REQ-022 An accepted beat with lst_i=1 SHALL set done_o together with val_o and move the FSM to IDLE.
REQ-023 If lst_i=0, nbyte_i SHALL be ignored.
REQ-024 start_i while in ACTV SHALL restart the computation: crc_r <= CRC_INIT, state stays ACTV, any beat in that cycle is discarded, and no val_o is generated for it.
REQ-025 val_i while in IDLE SHALL be ignored, including a val_i asserted in the same cycle as start_i.
REQ-026 val_i=0 while in ACTV SHALL leave crc_r, dat_o and state unchanged.
REQ-027 For DATA_WD=8, nbyte_i SHALL be 1 bit wide and ignored, and every beat SHALL carry one byte.

Reset
REQ-028 When rstn=0, the block SHALL asynchronously set: state=IDLE, crc_r=0, dat_o=0, val_o=0, done_o=0, rdy_o=0.
REQ-029 Reset asserted mid-message SHALL discard the message; after release, no val_o or done_o SHALL occur until a new start_i is followed by an accepted beat.

Verification
REQ-030 DATA_WD=32: start, then "1234","5678","9" with lst_i=1 and nbyte_i=1 -> val_o on three cycles; dat_o = 0x9BE3E0A3 after the first beat; final dat_o=0xCBF43926 with done_o=1.
REQ-031 DATA_WD=32: single beat "IEND" (0x49454E44) with lst_i=1 and nbyte_i=0 -> dat_o=0xAE426082, done_o=1, rdy_o=0 on the next cycle.
REQ-032 DATA_WD=8: bytes "123456789", one per cycle with idle gaps between them -> final dat_o=0xCBF43926, and dat_o stable during the gaps.
REQ-033 DATA_WD=64: start, then beat 0x3132333435363738 followed by 0x39xxxxxxxxxxxxxx with lst_i=1 and nbyte_i=1 -> dat_o=0xCBF43926.
REQ-034 Restart, DATA_WD=32: start, "ABCD", start with val_i=1 in the same cycle, then "IEND" last -> no val_o for the discarded beat; final dat_o=0xAE426082.
REQ-035 Reset mid-message: assert rstn=0 after the first beat -> all outputs 0; after release, driving val_i without start_i -> no val_o.

Source files
------------

// File: rtl/crc32_mb.sv
// Multi-byte reflected CRC-32 (0xEDB88320), DATA_WD/8 bytes per beat.
// Ports: clk, rstn, start_i, val_i, dat_i, lst_i, nbyte_i -> rdy_o, val_o, dat_o, done_o.
module crc32_mb #(
  parameter int          DATA_WD  = 32,
  parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF,
  parameter logic [31:0] XOR_OUT  = 32'hFFFF_FFFF,
  localparam int         LANE     = DATA_WD / 8,
  localparam int         NB_W     = (LANE > 1) ? $clog2(LANE) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic               val_i,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic               lst_i,
  input  logic [NB_W-1:0]    nbyte_i,
  output logic               rdy_o,
  output logic               val_o,
  output logic [31:0]        dat_o,
  output logic               done_o
);

  typedef enum logic {IDLE = 1'b0, ACTV = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_crc;
  logic [NB_W:0] w_len;
  logic [31:0] w_next;
  logic        w_unused;

  function automatic logic [31:0] f_crc8(
    input logic [31:0] c_in,
    input logic [7:0]  b
  );
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Byte count for this beat; 0 on a last beat means a full lane.
  always_comb begin
    w_len = (NB_W+1)'(LANE);
    if (LANE > 1 && lst_i && nbyte_i != '0) begin
      w_len = {1'b0, nbyte_i};
    end
  end

  // Chain all lanes MSB-first, tapping the running CRC after w_len bytes.
  always_comb begin
    logic [31:0] c;
    c      = r_crc;
    w_next = r_crc;
    for (int k = 0; k < LANE; k++) begin
      c = f_crc8(c, dat_i[DATA_WD-1-8*k -: 8]);
      if (w_len == (NB_W+1)'(k + 1)) begin
        w_next = c;
      end
    end
  end

  assign w_unused = ^nbyte_i;
  assign rdy_o    = (r_state == ACTV);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_crc   <= '0;
      dat_o   <= '0;
      val_o   <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      val_o  <= 1'b0;
      done_o <= 1'b0;
      if (start_i) begin
        // Restart wins over any beat presented in the same cycle.
        r_state <= ACTV;
        r_crc   <= CRC_INIT;
      end else if (r_state == ACTV && val_i) begin
        r_crc <= w_next;
        dat_o <= w_next ^ XOR_OUT;
        val_o <= 1'b1;
        if (lst_i) begin
          done_o  <= 1'b1;
          r_state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc32_mb.sv
// Directed checks of crc32_mb at 8, 32 and 64-bit beat widths.
// Known CRC-32 values of short strings serve as references.
module tb_crc32_mb;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit instance
  logic        a_st = 0, a_vl = 0, a_ls = 0;
  logic [31:0] a_d = '0;
  logic [1:0]  a_nb = '0;
  logic        a_rdy, a_val, a_done;
  logic [31:0] a_dat;

  // 8-bit instance
  logic        b_st = 0, b_vl = 0, b_ls = 0;
  logic [7:0]  b_d = '0;
  logic [0:0]  b_nb = '0;
  logic        b_rdy, b_val, b_done;
  logic [31:0] b_dat;

  // 64-bit instance
  logic        c_st = 0, c_vl = 0, c_ls = 0;
  logic [63:0] c_d = '0;
  logic [2:0]  c_nb = '0;
  logic        c_rdy, c_val, c_done;
  logic [31:0] c_dat;

  crc32_mb #(.DATA_WD(32)) u32 (
    .clk(clk), .rstn(rstn), .start_i(a_st), .val_i(a_vl),
    .dat_i(a_d), .lst_i(a_ls), .nbyte_i(a_nb), .rdy_o(a_rdy),
    .val_o(a_val), .dat_o(a_dat), .done_o(a_done));

  crc32_mb #(.DATA_WD(8)) u8 (
    .clk(clk), .rstn(rstn), .start_i(b_st), .val_i(b_vl),
    .dat_i(b_d), .lst_i(b_ls), .nbyte_i(b_nb), .rdy_o(b_rdy),
    .val_o(b_val), .dat_o(b_dat), .done_o(b_done));

  crc32_mb #(.DATA_WD(64)) u64 (
    .clk(clk), .rstn(rstn), .start_i(c_st), .val_i(c_vl),
    .dat_i(c_d), .lst_i(c_ls), .nbyte_i(c_nb), .rdy_o(c_rdy),
    .val_o(c_val), .dat_o(c_dat), .done_o(c_done));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic        st;
    logic        vl;
    logic [31:0] d;
    logic        ls;
    logic [1:0]  nb;
    logic        ev;
    logic        ed;
    logic        er;
    logic        cd;
    logic [31:0] edat;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input string nm, input logic st, input logic vl,
    input logic [31:0] d, input logic ls, input logic [1:0] nb,
    input logic ev, input logic ed, input logic er,
    input logic cd, input logic [31:0] edat);
    vec_t v;
    v.nm = nm; v.st = st; v.vl = vl; v.d = d; v.ls = ls; v.nb = nb;
    v.ev = ev; v.ed = ed; v.er = er; v.cd = cd; v.edat = edat;
    return v;
  endfunction

  logic [31:0] hold;
  logic [7:0]  msg [9];

  initial begin
    //          name       st vl data          ls nb  val dn rdy cd dat
    tv.push_back(mk("start",  1,0,32'h0,        0,0,  0,0,1, 1,32'h0));
    tv.push_back(mk("b1234",  0,1,32'h31323334, 0,0,  1,0,1, 1,32'h9BE3E0A3));
    tv.push_back(mk("gap",    0,0,32'hDEADBEEF, 0,0,  0,0,1, 1,32'h9BE3E0A3));
    tv.push_back(mk("b5678",  0,1,32'h35363738, 0,0,  1,0,1, 1,32'h9AE0DAAF));
    tv.push_back(mk("b9",     0,1,32'h39AABBCC, 1,1,  1,1,0, 1,32'hCBF43926));
    tv.push_back(mk("idlev",  0,1,32'h49454E44, 1,0,  0,0,0, 1,32'hCBF43926));
    tv.push_back(mk("stv",    1,1,32'h41424344, 0,0,  0,0,1, 1,32'hCBF43926));
    tv.push_back(mk("iend",   0,1,32'h49454E44, 1,0,  1,1,0, 1,32'hAE426082));
    tv.push_back(mk("idle",   0,0,32'h0,        0,0,  0,0,0, 1,32'hAE426082));
    tv.push_back(mk("st2",    1,0,32'h0,        0,0,  0,0,1, 0,32'h0));
    tv.push_back(mk("abcd",   0,1,32'h41424344, 0,0,  1,0,1, 0,32'h0));
    tv.push_back(mk("rst_v",  1,1,32'h41424344, 0,0,  0,0,1, 0,32'h0));
    tv.push_back(mk("iend2",  0,1,32'h49454E44, 1,0,  1,1,0, 1,32'hAE426082));
    tv.push_back(mk("st3",    1,0,32'h0,        0,0,  0,0,1, 0,32'h0));
    tv.push_back(mk("abc",    0,1,32'h61626300, 1,3,  1,1,0, 1,32'h352441C2));
    tv.push_back(mk("st4",    1,0,32'h0,        0,0,  0,0,1, 0,32'h0));
    tv.push_back(mk("a",      0,1,32'h61FFFFFF, 1,1,  1,1,0, 1,32'hE8B7BE43));
    tv.push_back(mk("st5",    1,0,32'h0,        0,0,  0,0,1, 0,32'h0));
    tv.push_back(mk("nbign",  0,1,32'h31323334, 0,1,  1,0,1, 1,32'h9BE3E0A3));
    tv.push_back(mk("rst_i",  1,0,32'h0,        0,0,  0,0,1, 1,32'h9BE3E0A3));
    tv.push_back(mk("iend3",  0,1,32'h49454E44, 1,0,  1,1,0, 1,32'hAE426082));

    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
            8'h36, 8'h37, 8'h38, 8'h39};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy32", {31'd0, a_rdy}, 32'd0);
    chk("rst_val32", {31'd0, a_val}, 32'd0);
    chk("rst_dat32", a_dat, 32'd0);
    chk("rst_rdy8",  {31'd0, b_rdy}, 32'd0);
    chk("rst_dat64", c_dat, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven 32-bit sequence
    foreach (tv[i]) begin
      @(negedge clk);
      a_st = tv[i].st; a_vl = tv[i].vl; a_d = tv[i].d;
      a_ls = tv[i].ls; a_nb = tv[i].nb;
      @(posedge clk);
      #1;
      chk({tv[i].nm, ".val"}, {31'd0, a_val}, {31'd0, tv[i].ev});
      chk({tv[i].nm, ".done"}, {31'd0, a_done}, {31'd0, tv[i].ed});
      chk({tv[i].nm, ".rdy"}, {31'd0, a_rdy}, {31'd0, tv[i].er});
      if (tv[i].cd) chk({tv[i].nm, ".dat"}, a_dat, tv[i].edat);
    end
    @(negedge clk);
    a_st = 0; a_vl = 0; a_ls = 0; a_nb = 0;

    // 8-bit: one byte per beat with idle gaps
    b_st = 1;
    @(negedge clk);
    b_st = 0;
    chk("b8_rdy", {31'd0, b_rdy}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      b_vl = 1; b_d = msg[i]; b_ls = (i == 8); b_nb = 1'b1;
      @(posedge clk);
      #1;
      chk("b8_val", {31'd0, b_val}, 32'd1);
      chk("b8_done", {31'd0, b_done}, {31'd0, (i == 8)});
      if (i == 0) chk("b8_first", b_dat, 32'h83DCEFB7);
      hold = b_dat;
      @(negedge clk);
      b_vl = 0; b_d = 8'hFF; b_ls = 0;
      repeat (2) begin
        @(posedge clk);
        #1;
        chk("b8_gapval", {31'd0, b_val}, 32'd0);
        chk("b8_hold", b_dat, hold);
      end
      @(negedge clk);
    end
    chk("b8_final", b_dat, 32'hCBF43926);
    chk("b8_idle", {31'd0, b_rdy}, 32'd0);

    // 64-bit: full beat then 1-byte tail
    c_st = 1;
    @(negedge clk);
    c_st = 0; c_vl = 1; c_d = 64'h3132333435363738;
    @(posedge clk);
    #1;
    chk("b64_first", c_dat, 32'h9AE0DAAF);
    chk("b64_v1", {31'd0, c_val}, 32'd1);
    @(negedge clk);
    c_d = 64'h39AABBCCDDEEFF00; c_ls = 1; c_nb = 3'd1;
    @(posedge clk);
    #1;
    chk("b64_final", c_dat, 32'hCBF43926);
    chk("b64_done", {31'd0, c_done}, 32'd1);
    @(negedge clk);
    c_vl = 0; c_ls = 0; c_st = 1;
    @(negedge clk);
    c_st = 0; c_vl = 1; c_ls = 1; c_nb = 3'd3;
    c_d = 64'h6162630011223344;
    @(posedge clk);
    #1;
    chk("b64_abc", c_dat, 32'h352441C2);
    @(negedge clk);
    c_vl = 0; c_ls = 0; c_nb = 0;

    // Reset mid-message
    a_st = 1;
    @(negedge clk);
    a_st = 0; a_vl = 1; a_d = 32'h31323334;
    @(posedge clk);
    #1;
    chk("mid_beat", a_dat, 32'h9BE3E0A3);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rdy", {31'd0, a_rdy}, 32'd0);
    chk("mid_val", {31'd0, a_val}, 32'd0);
    chk("mid_dat", a_dat, 32'd0);
    chk("mid_done", {31'd0, a_done}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    a_d = 32'h49454E44; a_ls = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_val", {31'd0, a_val}, 32'd0);
      chk("post_done", {31'd0, a_done}, 32'd0);
      chk("post_rdy", {31'd0, a_rdy}, 32'd0);
    end
    chk("post_dat", a_dat, 32'd0);
    @(negedge clk);
    a_vl = 0; a_ls = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
